// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider bank.
package clk_div_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 18;  // covers the 2^17 keyboard-scan half-period
  localparam int DEF_HALF   = 5;   // 50 MHz -> 5 MHz

  // Channel-index width; a single-channel bank still needs a 1-bit index.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration and output bundle of the clock divider bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              sync_restart;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  modport master (
    output cfg_we, cfg_ch, cfg_half, sync_restart,
    input  clk_out, tick, pending
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_half, sync_restart,
    output clk_out, tick, pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadowed reload, registered clock and tick.
module clk_div_channel #(
  parameter int CNT_W        = 18,
  parameter int DEFAULT_HALF = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CNT_W-1:0] half_in,
  input  logic             restart,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
  logic             disabled, wrap;

  assign disabled = (active_q == '0);
  assign wrap     = !disabled && (count_q == active_q - 1'b1);

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path can infer a latch.
    count_d  = count_q;
    active_d = active_q;
    shadow_d = shadow_q;
    clk_d    = clk_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    if (restart) begin
      active_d = we ? half_in : shadow_q;
      shadow_d = active_d;
      pend_d   = 1'b0;
      count_d  = '0;
      clk_d    = 1'b0;
    end else if (disabled) begin
      // An idle channel has no wrap to wait for, so any new value commits at once.
      if (we)          active_d = half_in;
      else if (pend_q) active_d = shadow_q;
      shadow_d = active_d;
      pend_d   = 1'b0;
      count_d  = '0;
      clk_d    = 1'b0;
    end else begin
      if (wrap) begin
        count_d = '0;
        clk_d   = ~clk_q;
        tick_d  = ~clk_q;
        if (pend_q) begin
          active_d = shadow_q;
          pend_d   = 1'b0;
          if (shadow_q == '0) begin
            clk_d  = 1'b0;
            tick_d = 1'b0;
          end
        end
      end else begin
        count_d = count_q + 1'b1;
      end
      // A write on the wrap edge lands in the shadow after the old value was taken.
      if (we) begin
        shadow_d = half_in;
        pend_d   = 1'b1;
      end
    end
  end

  // State advances on the falling edge to stay phase-compatible with the older dividers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only a handful of control flops here, so all of them get a reset value.
      count_q  <= '0;
      active_q <= CNT_W'(DEFAULT_HALF);
      shadow_q <= CNT_W'(DEFAULT_HALF);
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one system clock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_div_bank_if.slave  bus
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] clk_out_w, tick_w, pending_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // Out-of-range indices match no channel, so such writes fall through untouched.
    assign ch_we = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (ch_we),
      .half_in (bus.cfg_half),
      .restart (bus.sync_restart),
      .clk_out (clk_out_w[i]),
      .tick    (tick_w[i]),
      .pending (pending_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pending_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised and directed checks of clk_div_bank against an edge-time reference model.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 18;
  localparam int CHW = ch_idx_w(NCH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Reference model: each running channel knows the absolute edge of its next toggle.
  int unsigned m_h [NCH];
  int unsigned m_sh[NCH];
  longint      m_nxt[NCH];
  bit          m_lvl[NCH], m_pend[NCH], m_tick[NCH];
  longint      t;

  function automatic void model_reset();
    t = 0;
    for (int i = 0; i < NCH; i++) begin
      m_h[i] = 5; m_sh[i] = 5; m_nxt[i] = 5;
      m_lvl[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
    end
  endfunction

  function automatic void model_edge(input bit we, input int ch, input int unsigned d, input bit rs);
    t++;
    for (int i = 0; i < NCH; i++) begin
      bit w;
      w = we && (ch == i);
      m_tick[i] = 0;
      if (rs) begin
        m_h[i] = w ? d : m_sh[i];
        m_sh[i] = m_h[i]; m_pend[i] = 0; m_lvl[i] = 0;
        m_nxt[i] = t + longint'(m_h[i]);
      end else if (m_h[i] == 0) begin
        if (w) m_h[i] = d;
        else if (m_pend[i]) m_h[i] = m_sh[i];
        m_sh[i] = m_h[i]; m_pend[i] = 0; m_lvl[i] = 0;
        m_nxt[i] = t + longint'(m_h[i]);
      end else begin
        if (t == m_nxt[i]) begin
          m_lvl[i] = !m_lvl[i];
          m_tick[i] = m_lvl[i];
          if (m_pend[i]) begin m_h[i] = m_sh[i]; m_pend[i] = 0; end
          if (m_h[i] == 0) begin m_lvl[i] = 0; m_tick[i] = 0; end
          m_nxt[i] = t + longint'(m_h[i]);
        end
        if (w) begin m_sh[i] = d; m_pend[i] = 1; end
      end
    end
  endfunction

  // Called at a rising edge: drive inputs, let the falling edge act, compare at the next rise.
  task automatic step(input bit we, input int ch, input int unsigned d, input bit rs);
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    bus.cfg_we       = we;
    bus.cfg_ch       = CHW'(ch);
    bus.cfg_half     = CW'(d);
    bus.sync_restart = rs;
    model_edge(we, ch, d, rs);
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      e_clk[i] = m_lvl[i]; e_tick[i] = m_tick[i]; e_pend[i] = m_pend[i];
    end
    check("clk_out", 32'(bus.clk_out), 32'(e_clk));
    check("tick",    32'(bus.tick),    32'(e_tick));
    check("pending", 32'(bus.pending), 32'(e_pend));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    int ticks, highs;
    int first_tick[NCH];
    rst_n = 1'b0;
    bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_half = '0; bus.sync_restart = 0;
    repeat (3) @(posedge clk);
    check("reset_clk_out", 32'(bus.clk_out), 0);
    check("reset_tick",    32'(bus.tick),    0);
    check("reset_pending", 32'(bus.pending), 0);
    rst_n = 1'b1;
    model_reset();

    // Default ratio: 10-clock period, 5 high, one tick per period.
    ticks = 0; highs = 0;
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0, 0);
      ticks += int'(bus.tick[4]);
      highs += int'(bus.clk_out[4]);
    end
    check("default_ticks_100", ticks, 10);
    check("default_high_100",  highs, 50);

    // Mid-phase reload of ch1.
    idle(2);
    step(1, 1, 3, 0);
    check("ch1_pending_after_write", 32'(bus.pending[1]), 1);
    idle(30);

    // Disable ch2, then re-enable while idle: immediate commit.
    step(1, 2, 0, 0);
    idle(12);
    check("ch2_idle_low", 32'(bus.clk_out[2]), 0);
    step(1, 2, 2, 0);
    check("ch2_no_pending", 32'(bus.pending[2]), 0);
    step(0, 0, 0, 0);
    check("ch2_tick_early", 32'(bus.tick[2]), 0);
    step(0, 0, 0, 0);
    check("ch2_first_tick", 32'(bus.tick[2]), 1);
    idle(20);

    // Double write on ch0: last one wins.
    step(1, 0, 7, 0);
    step(1, 0, 4, 0);
    idle(40);

    // Differing ratios, one pending write, then a common restart.
    step(1, 0, 5, 0); step(1, 1, 3, 0); step(1, 2, 2, 0); step(1, 3, 1, 0);
    idle(30);
    step(1, 4, 6, 0);
    step(0, 0, 0, 1);
    check("restart_clk_low",    32'(bus.clk_out), 0);
    check("restart_no_pending", 32'(bus.pending), 0);
    for (int i = 0; i < NCH; i++) first_tick[i] = 0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      for (int i = 0; i < NCH; i++)
        if (bus.tick[i] && first_tick[i] == 0) first_tick[i] = k;
    end
    check("restart_tick_ch0", first_tick[0], 5);
    check("restart_tick_ch1", first_tick[1], 3);
    check("restart_tick_ch2", first_tick[2], 2);
    check("restart_tick_ch3", first_tick[3], 1);
    check("restart_tick_ch4", first_tick[4], 6);

    // Restart coincident with a write, then out-of-range writes.
    step(1, 1, 4, 1);
    idle(10);
    step(1, 5, 0, 0); step(1, 6, 1, 0); step(1, 7, 2, 0);
    idle(20);

    // Randomised traffic including invalid indices and restarts.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7),
           $urandom_range(0, 6), $urandom_range(0, 199) == 0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(bus.clk_out), 0);
    check("async_rst_tick",    32'(bus.tick),    0);
    check("async_rst_pending", 32'(bus.pending), 0);
    bus.cfg_we = 0; bus.sync_restart = 0;
    @(posedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(15);

    // Keyboard-scan ratio: disable ch4, then load 131072 immediately.
    step(1, 4, 0, 0);
    idle(12);
    step(1, 4, 131072, 0);
    ticks = 0;
    for (int k = 0; k < 2000; k++) begin
      step(0, 0, 0, 0);
      ticks += int'(bus.tick[4]);
    end
    check("kbd_no_tick_yet", ticks, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised multi-channel clock divider; the successor to the fixed 50M->5M and keyboard-scan dividers.
- NUM_CH independent channels run from one system clock.
- Each channel has a run-time programmable half-period, glitch-free reload, a one-cycle rising-edge tick, and a common synchronous restart.
- Sits at top level and feeds serial baud, keyboard scan and display refresh logic.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 18, half-period counter width; covers 2^17 keyboard-scan divide.
- DEFAULT_HALF, 5, half-period loaded into every channel at reset (50M -> 5M).

Ports:
- clk  input  1  system clock; all state updates on falling edge, matching existing dividers.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  config write strobe, sampled on the clock edge.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index.
- cfg_half  input  CNT_W  new half-period; 0 = channel disabled.
- sync_restart  input  1  restart all channels in phase.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle pulse per channel, coincident with the clk_out 0->1 transition.
- pending  output  NUM_CH  high while a written value awaits commit.

Behaviour:
- Reset (async, rst_n=0):
  - active_half = DEFAULT_HALF and shadow = DEFAULT_HALF for every channel.
  - count = 0, clk_out = 0, tick = 0, pending = 0.
- Per channel, active_half H >= 1:
  - count increments by 1 each clock.
  - When count == H-1 ("wrap"): count <= 0 and clk_out toggles.
  - Output period = 2H clocks, 50% duty. H=1 gives clk/2.
  - tick = 1 for exactly the cycle in which clk_out becomes 1; otherwise 0.
- H == 0 (disabled):
  - count held 0, clk_out forced 0 on the next edge, tick 0.
- Config write (cfg_we=1, cfg_ch < NUM_CH):
  - cfg_half is stored to shadow and pending is set.
  - cfg_ch >= NUM_CH: write ignored, no state change.
- Commit (shadow -> active_half, pending cleared) happens at:
  - the next wrap of that channel (glitch-free: no partial half-periods), or
  - immediately on the write edge if the channel is currently disabled; count restarts at 0, clk_out = 0, pending never visibly set.
- Write on the same edge as a wrap of that channel:
  - the current wrap uses the old H; the new value commits at the following wrap.
- Second write while pending: shadow is overwritten (last write wins) and pending stays 1.
- Writing 0: the channel disables at its next wrap; clk_out is then 0, which may truncate a high phase — accepted.
- sync_restart=1, on that edge, for all channels:
  - count <= 0, clk_out <= 0, tick <= 0, and any pending shadow commits.
  - If cfg_we is on the same edge, the written value commits immediately too.
  - sync_restart has priority over wrap.
- Counter arithmetic: unsigned, CNT_W bits, no overflow possible since count < H <= 2^CNT_W-1.
- Outputs are all registered; no combinational paths from inputs to outputs.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W default.
  - DEFAULT_HALF constant.
  - localparam helpers for channel-index width.
- Sub-module clk_div_channel (one per channel, generate loop) holds count, active_half, shadow, pending, clk_out and tick.
- The top level does address decode of cfg_ch into per-channel write enables and fans out sync_restart.

Test Plan:
- Reset release, DEFAULT_HALF=5 -> every clk_out period is 10 clocks, 5 high / 5 low; tick asserted 1 cycle every 10 clocks; pending=0.
- Write ch1 half=3 mid-phase -> pending[1]=1 until the next ch1 wrap; then period becomes 6 clocks, with no half-period shorter than 3 or 5 clocks.
- Write ch2 half=0, then half=2 -> ch2 idles at 0 after its wrap; the second write restarts it immediately (pending never visible) with period 4 and first tick 2 clocks later.
- Write ch0 twice (7 then 4) before a wrap -> only 4 is committed; ch0 never shows period 14.
- sync_restart after differing ratios (5,3,2,1) -> all clk_out=0 next edge; first ticks at clocks 5,3,2,1 after restart; pending commits observed.
- Assert rst_n=0 mid-operation, asynchronously between edges -> outputs go 0 immediately; writes to cfg_ch >= NUM_CH are ignored; keyboard case half=131072 gives period 262144.
